// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one combinational ALU: grants round-robin in IDLE, presents registered
// operands for one settle cycle, then captures the result and pulses the owner's DONE.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OPRN_WIDTH = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic [DATA_WIDTH-1:0] OP1_0,
  input  logic [DATA_WIDTH-1:0] OP2_0,
  input  logic [OPRN_WIDTH-1:0] OPRN_0,
  input  logic                  REQ1,
  input  logic [DATA_WIDTH-1:0] OP1_1,
  input  logic [DATA_WIDTH-1:0] OP2_1,
  input  logic [OPRN_WIDTH-1:0] OPRN_1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ZERO_OUT,
  output logic                  ILLEGAL,
  output logic                  OWNER,
  output logic                  BUSY,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10,
    StBad  = 2'b11
  } state_e;

  state_e                  state_q;
  logic                    done0_q, done1_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q;
  logic                    illegal_q;
  logic                    owner_q;
  logic                    last_gnt_q;
  logic [DATA_WIDTH-1:0]   alu_op1_q, alu_op2_q;
  logic [OPRN_WIDTH-1:0]   alu_oprn_q;

  logic any_req;
  logic gnt1;
  logic oprn_illegal;

  // On a tie the port that did not win last time is granted.
  assign any_req      = REQ0 | REQ1;
  assign gnt1         = REQ1 & (~REQ0 | ~last_gnt_q);
  assign oprn_illegal = (alu_oprn_q == '0) || (alu_oprn_q > OPRN_WIDTH'(9));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      alu_oprn_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            alu_op1_q  <= gnt1 ? OP1_1  : OP1_0;
            alu_op2_q  <= gnt1 ? OP2_1  : OP2_0;
            alu_oprn_q <= gnt1 ? OPRN_1 : OPRN_0;
            owner_q    <= gnt1;
            last_gnt_q <= gnt1;
            state_q    <= StExec;
          end
        end
        StExec: begin
          result_q  <= ALU_OUT;
          zero_q    <= ALU_ZERO;
          illegal_q <= oprn_illegal;
          done0_q   <= ~owner_q;
          done1_q   <= owner_q;
          state_q   <= StDone;
        end
        StDone: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign DONE0    = done0_q;
  assign DONE1    = done1_q;
  assign RESULT   = result_q;
  assign ZERO_OUT = zero_q;
  assign ILLEGAL  = illegal_q;
  assign OWNER    = owner_q;
  assign BUSY     = (state_q != StIdle);
  assign ALU_OP1  = alu_op1_q;
  assign ALU_OP2  = alu_op2_q;
  assign ALU_OPRN = alu_oprn_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU closing the loop.
module tb_alu_share_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [31:0] OP1_0 = '0, OP2_0 = '0, OP1_1 = '0, OP2_1 = '0;
  logic [5:0]  OPRN_0 = '0, OPRN_1 = '0;
  logic        DONE0, DONE1, ZERO_OUT, ILLEGAL, OWNER, BUSY;
  logic [31:0] RESULT, ALU_OP1, ALU_OP2, ALU_OUT;
  logic [5:0]  ALU_OPRN;
  logic        ALU_ZERO;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  alu_share_arbiter #(
    .DATA_WIDTH(32),
    .OPRN_WIDTH(6)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ0    (REQ0),
    .OP1_0   (OP1_0),
    .OP2_0   (OP2_0),
    .OPRN_0  (OPRN_0),
    .REQ1    (REQ1),
    .OP1_1   (OP1_1),
    .OP2_1   (OP2_1),
    .OPRN_1  (OPRN_1),
    .DONE0   (DONE0),
    .DONE1   (DONE1),
    .RESULT  (RESULT),
    .ZERO_OUT(ZERO_OUT),
    .ILLEGAL (ILLEGAL),
    .OWNER   (OWNER),
    .BUSY    (BUSY),
    .ALU_OP1 (ALU_OP1),
    .ALU_OP2 (ALU_OP2),
    .ALU_OPRN(ALU_OPRN),
    .ALU_OUT (ALU_OUT),
    .ALU_ZERO(ALU_ZERO)
  );

  always #5 CLK = ~CLK;

  // Reference ALU; unsupported opcodes return 0.
  always_comb begin
    ALU_OUT = '0;
    case (ALU_OPRN)
      6'h01: ALU_OUT = ALU_OP1 + ALU_OP2;
      6'h02: ALU_OUT = ALU_OP1 - ALU_OP2;
      6'h03: ALU_OUT = ALU_OP1 * ALU_OP2;
      6'h04: ALU_OUT = ALU_OP1 >> ALU_OP2;
      6'h05: ALU_OUT = ALU_OP1 << ALU_OP2;
      6'h06: ALU_OUT = ALU_OP1 & ALU_OP2;
      6'h07: ALU_OUT = ALU_OP1 | ALU_OP2;
      6'h08: ALU_OUT = ~(ALU_OP1 | ALU_OP2);
      6'h09: ALU_OUT = ($signed(ALU_OP1) < $signed(ALU_OP2)) ? 32'd1 : 32'd0;
      default: ALU_OUT = '0;
    endcase
    ALU_ZERO = (ALU_OUT == '0);
  end

  always @(negedge CLK) if (DONE0 && DONE1) overlap++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_done0", DONE0, 0);
    chk("rst_done1", DONE1, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_zero", ZERO_OUT, 0);
    chk("rst_illegal", ILLEGAL, 0);
    chk("rst_owner", OWNER, 0);
    chk("rst_aluop1", ALU_OP1, 0);
    chk("rst_aluoprn", ALU_OPRN, 0);

    // Single add 5+7
    REQ0 = 1; OP1_0 = 5; OP2_0 = 7; OPRN_0 = 6'h01;
    tick();
    chk("add_busy", BUSY, 1);
    chk("add_aluoprn", ALU_OPRN, 6'h01);
    chk("add_aluop1", ALU_OP1, 5);
    chk("add_aluop2", ALU_OP2, 7);
    chk("add_done0_early", DONE0, 0);
    tick();
    chk("add_done0", DONE0, 1);
    chk("add_done1", DONE1, 0);
    chk("add_result", RESULT, 12);
    chk("add_zero", ZERO_OUT, 0);
    chk("add_illegal", ILLEGAL, 0);
    chk("add_owner", OWNER, 0);
    REQ0 = 0;
    tick();
    chk("add_done0_clr", DONE0, 0);
    chk("add_idle", BUSY, 0);

    // Tie after reset: port 0 first, port 1 three cycles later
    do_reset();
    REQ0 = 1; OP1_0 = 3;  OP2_0 = 4;  OPRN_0 = 6'h01;
    REQ1 = 1; OP1_1 = 10; OP2_1 = 10; OPRN_1 = 6'h02;
    tick();
    chk("tie_owner0", OWNER, 0);
    tick();
    chk("tie_done0", DONE0, 1);
    chk("tie_result0", RESULT, 7);
    REQ0 = 0;
    tick();
    chk("tie_done1_t2", DONE1, 0);
    tick();
    chk("tie_owner1", OWNER, 1);
    chk("tie_done1_t3", DONE1, 0);
    tick();
    chk("tie_done1", DONE1, 1);
    chk("tie_result1", RESULT, 0);
    chk("tie_zero1", ZERO_OUT, 1);
    REQ1 = 0;
    tick();

    // Round-robin under continuous double request; port 1 was last granted
    REQ0 = 1; OP1_0 = 1; OP2_0 = 2; OPRN_0 = 6'h01;
    REQ1 = 1; OP1_1 = 9; OP2_1 = 4; OPRN_1 = 6'h02;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_owner", OWNER, i % 2);
      tick();
      chk("rr_done0", DONE0, (i % 2) == 0);
      chk("rr_done1", DONE1, (i % 2) == 1);
      chk("rr_result", RESULT, (i % 2) ? 5 : 3);
      if (i == 7) begin
        REQ0 = 0;
        REQ1 = 0;
      end
      tick();
    end
    chk("rr_idle", BUSY, 0);

    // Reset during EXEC of a port-1 op
    REQ1 = 1; OP1_1 = 20; OP2_1 = 22; OPRN_1 = 6'h01;
    tick();
    chk("mid_exec", BUSY, 1);
    RST = 1; REQ1 = 0;
    tick();
    RST = 0;
    chk("mid_done1", DONE1, 0);
    chk("mid_busy", BUSY, 0);
    chk("mid_result", RESULT, 0);
    chk("mid_aluop1", ALU_OP1, 0);
    chk("mid_aluoprn", ALU_OPRN, 0);
    chk("mid_owner", OWNER, 0);
    tick();
    chk("mid_done1_late", DONE1, 0);
    REQ1 = 1;
    tick();
    chk("post_owner", OWNER, 1);
    tick();
    chk("post_done1", DONE1, 1);
    chk("post_result", RESULT, 42);
    REQ1 = 0;
    tick();

    // Illegal opcode, then a valid op clears ILLEGAL
    REQ1 = 1; OP1_1 = 5; OP2_1 = 6; OPRN_1 = 6'h0A;
    tick();
    tick();
    chk("ill_done1", DONE1, 1);
    chk("ill_result", RESULT, 0);
    chk("ill_zero", ZERO_OUT, 1);
    chk("ill_flag", ILLEGAL, 1);
    REQ1 = 0;
    tick();
    REQ0 = 1; OP1_0 = 1; OP2_0 = 1; OPRN_0 = 6'h01;
    tick();
    tick();
    chk("clr_done0", DONE0, 1);
    chk("clr_result", RESULT, 2);
    chk("clr_illegal", ILLEGAL, 0);
    REQ0 = 0;
    tick();

    // Signed set-less-than; operand change after grant must be ignored
    REQ0 = 1; OP1_0 = 32'hFFFF_FFFF; OP2_0 = 1; OPRN_0 = 6'h09;
    tick();
    OP1_0 = 5;
    tick();
    chk("slt_done0", DONE0, 1);
    chk("slt_result", RESULT, 1);
    chk("slt_zero", ZERO_OUT, 0);
    REQ0 = 0;
    tick();

    chk("done_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
